// File: rtl/nor_out_debounce_event.sv
// Synchronises and debounces a NOR gate output into a clean level with rise/fall pulses and queued edge events.
// Latency is SYNC_STAGES+STABLE_CYCLES edges from a stable Y to Q. A full FIFO with no pop drops the new event and sets sticky OVF.
module nor_out_debounce_event #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic Y,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic EV_VALID,
    output logic EV_DATA,
    input  logic EV_READY,
    output logic OVF
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   toggle;

    logic [FIFO_DEPTH-1:0]  mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEVEL_W-1:0]     level;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push_ok;

    assign s      = sync_q[SYNC_STAGES-1];
    assign toggle = (s != Q) && (cnt == CNT_LAST);

    // Counter only runs while S disagrees with Q, so it never exceeds CNT_LAST.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q <= '0;
            cnt    <= '0;
            Q      <= 1'b0;
            RISE   <= 1'b0;
            FALL   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Y};
            RISE   <= toggle & s;
            FALL   <= toggle & ~s;
            if (s == Q) begin
                cnt <= '0;
            end else if (toggle) begin
                Q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_FULL);
    assign pop     = ~empty & EV_READY;
    // A pop on the same edge frees the slot the push lands in.
    assign push_ok = toggle & (~full | pop);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= s;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
            if (toggle & full & ~pop) begin
                OVF <= 1'b1;
            end
        end
    end

    assign EV_VALID = ~empty;
    assign EV_DATA  = empty ? 1'b0 : mem[rd_ptr];

endmodule

// File: tb/tb_nor_out_debounce_event.sv
// Directed bench for nor_out_debounce_event: default instance plus a STABLE_CYCLES=1 instance.
module tb_nor_out_debounce_event;

    logic clk = 1'b0;
    logic rst_n;
    logic y, y1;
    logic ev_ready, ev_ready1;
    logic q, rise, fall, ev_valid, ev_data, ovf;
    logic q1, rise1, fall1, ev_valid1, ev_data1, ovf1;

    int total = 0;
    int bad   = 0;
    int rise_seen;

    always #5 clk = ~clk;

    nor_out_debounce_event #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RST_N(rst_n), .Y(y), .Q(q), .RISE(rise), .FALL(fall),
        .EV_VALID(ev_valid), .EV_DATA(ev_data), .EV_READY(ev_ready), .OVF(ovf)
    );

    nor_out_debounce_event #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
        .CLK(clk), .RST_N(rst_n), .Y(y1), .Q(q1), .RISE(rise1), .FALL(fall1),
        .EV_VALID(ev_valid1), .EV_DATA(ev_data1), .EV_READY(ev_ready1), .OVF(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; y = 1'b1; y1 = 1'b0; ev_ready = 1'b0; ev_ready1 = 1'b0;

        // Reset held for 3 edges with Y=1, then 6-edge latency to Q
        ticks(3);
        check("rst_q", q, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_rise", rise, 0);
        rst_n = 1'b1;
        ticks(5);
        check("lat_q_e5", q, 0);
        tick();
        check("lat_q_e6", q, 1);
        check("lat_rise_e6", rise, 1);
        check("lat_valid", ev_valid, 1);
        check("lat_data", ev_data, 1);
        tick();
        check("lat_rise_e7", rise, 0);

        // 3-cycle pulse rejected, then a full change still takes 6 edges
        y = 1'b0;
        do_reset();
        ticks(2);
        rise_seen = 0;
        y = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); rise_seen += int'(rise); end
        y = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); rise_seen += int'(rise); end
        check("glitch_rise", rise_seen, 0);
        check("glitch_q", q, 0);
        check("glitch_valid", ev_valid, 0);
        y = 1'b1;
        ticks(5);
        check("post_glitch_q_e5", q, 0);
        tick();
        check("post_glitch_q_e6", q, 1);

        // STABLE_CYCLES=1 instance: Q after edge 3
        y = 1'b0;
        do_reset();
        y1 = 1'b1;
        ticks(2);
        check("s1_q_e2", q1, 0);
        tick();
        check("s1_q_e3", q1, 1);
        check("s1_rise_e3", rise1, 1);
        check("s1_valid", ev_valid1, 1);
        tick();
        check("s1_rise_e4", rise1, 0);

        // Overflow: 5 events into a 4-deep FIFO with no consumer
        y = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            y = (i % 2 == 0);
            ticks(10);
            check("ovf_step", ovf, (i == 4));
        end
        check("ovf_q", q, 1);
        check("ovf_valid", ev_valid, 1);
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_valid", ev_valid, 1);
            check("ovf_drain_data", ev_data, (k % 2 == 0));
            tick();
        end
        check("ovf_empty", ev_valid, 0);
        check("ovf_sticky", ovf, 1);
        ev_ready = 1'b0;

        // Reset mid-operation with 2 queued events and a partial count
        y = 1'b0; ticks(10);
        y = 1'b1; ticks(10);
        check("mid_valid", ev_valid, 1);
        y = 1'b0;
        ticks(3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_q", q, 0);
        check("mid_rst_rise", rise, 0);
        check("mid_rst_fall", fall, 0);
        check("mid_rst_ovf", ovf, 0);
        rst_n = 1'b1;
        ticks(2);
        y = 1'b1;
        ticks(5);
        check("mid_lat_e5", q, 0);
        tick();
        check("mid_lat_e6", q, 1);

        // Full FIFO, push and pop on the same edge
        y = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            y = (i % 2 == 0);
            ticks(10);
        end
        check("full_ovf0", ovf, 0);
        y = 1'b1;
        ticks(5);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pp_rise", rise, 1);
        check("pp_ovf", ovf, 0);
        check("pp_valid", ev_valid, 1);
        check("pp_head", ev_data, 0);
        tick();
        check("pp_hold_data", ev_data, 0);
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("pp_drain_valid", ev_valid, 1);
            check("pp_drain_data", ev_data, (k % 2 == 1));
            tick();
        end
        check("pp_empty", ev_valid, 0);
        tick();
        check("pp_underflow_valid", ev_valid, 0);
        check("pp_underflow_data", ev_data, 0);
        check("pp_end_ovf", ovf, 0);
        ev_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
